// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: turns one PC-stage request into a 1- or 2-beat burst read
// and hands the fetched group to decode over a valid/ready handshake.
module ifetch_resp #(
    parameter int unsigned        DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_INST = 32'h03400000
) (
    input  logic              clk,
    input  logic              rst,
    // PC stage
    input  logic              inst_rreq,
    input  logic [DATA_W-1:0] pc,
    input  logic              iuncache,
    input  logic              flush,
    output logic              stall,
    // Instruction memory bus
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [DATA_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic              r_last,
    output logic              r_ready,
    // Decode
    output logic              inst_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] inst_pc,
    output logic [DATA_W-1:0] inst0,
    output logic [DATA_W-1:0] inst1,
    output logic              inst1_valid,
    output logic              fetch_excp
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAr   = 2'd1;
    localparam logic [1:0] StR    = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              two_q, two_d;       // 1: two-word fetch
    logic [1:0]        beat_q, beat_d;     // saturates at 2; later beats are ignored
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] inst0_q, inst0_d;
    logic [DATA_W-1:0] inst1_q, inst1_d;
    logic              inst1_valid_q, inst1_valid_d;
    logic              excp_q, excp_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        two_d         = two_q;
        beat_d        = beat_q;
        discard_d     = discard_q;
        inst0_d       = inst0_q;
        inst1_d       = inst1_q;
        inst1_valid_d = inst1_valid_q;
        excp_d        = excp_q;

        case (state_q)
            StIdle: begin
                discard_d = 1'b0;
                if (inst_rreq && !flush) begin
                    pc_d          = pc;
                    two_d         = ~iuncache;
                    beat_d        = 2'd0;
                    inst0_d       = NOP_INST;
                    inst1_d       = NOP_INST;
                    inst1_valid_d = 1'b0;
                    excp_d        = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned pc: report ADEF without touching the bus
                        excp_d  = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StAr;
                    end
                end
            end

            StAr: begin
                // ar_valid must not be retracted, so a flush is only remembered here
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (ar_ready) begin
                    beat_d  = 2'd0;
                    state_d = StR;
                end
            end

            StR: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (r_valid) begin
                    if (beat_q == 2'd0) begin
                        inst0_d = r_data;
                    end else if (beat_q == 2'd1) begin
                        inst1_d = r_data;
                    end
                    if (beat_q != 2'd2) begin
                        beat_d = beat_q + 2'd1;
                    end
                    if (r_last) begin
                        if (discard_q || flush) begin
                            discard_d = 1'b0;
                            state_d   = StIdle;
                        end else begin
                            inst1_valid_d = two_q && (beat_q != 2'd0);
                            state_d       = StResp;
                        end
                    end
                end
            end

            StResp: begin
                if (flush || out_ready) begin
                    discard_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            two_q         <= 1'b0;
            beat_q        <= 2'd0;
            discard_q     <= 1'b0;
            inst0_q       <= '0;
            inst1_q       <= '0;
            inst1_valid_q <= 1'b0;
            excp_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            two_q         <= two_d;
            beat_q        <= beat_d;
            discard_q     <= discard_d;
            inst0_q       <= inst0_d;
            inst1_q       <= inst1_d;
            inst1_valid_q <= inst1_valid_d;
            excp_q        <= excp_d;
        end
    end

    always_comb begin
        stall       = (state_q != StIdle);
        ar_valid    = (state_q == StAr);
        ar_addr     = pc_q;
        ar_len      = {7'd0, two_q};
        r_ready     = (state_q == StR);
        inst_valid  = (state_q == StResp);
        inst_pc     = pc_q;
        inst0       = inst0_q;
        inst1       = inst1_q;
        inst1_valid = inst1_valid_q;
        fetch_excp  = excp_q;
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// Self-checking bench for ifetch_resp: the bench plays PC stage, memory bus and decode, and
// predicts each transaction's bus request and delivered group from the fetch rules.
module tb_ifetch_resp;

    localparam logic [31:0] NOP = 32'h03400000;
    localparam int FNone = 0;
    localparam int FAr   = 1;
    localparam int FR    = 2;
    localparam int FLast = 3;
    localparam int FResp = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_rreq, iuncache, flush, ar_ready, r_valid, r_last, out_ready;
    logic [31:0] pc, r_data;
    logic        stall, ar_valid, r_ready, inst_valid, inst1_valid, fetch_excp;
    logic [31:0] ar_addr, inst_pc, inst0, inst1;
    logic [7:0]  ar_len;

    int n_vec = 0;
    int n_err = 0;

    ifetch_resp dut (
        .clk        (clk),
        .rst        (rst),
        .inst_rreq  (inst_rreq),
        .pc         (pc),
        .iuncache   (iuncache),
        .flush      (flush),
        .stall      (stall),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .r_last     (r_last),
        .r_ready    (r_ready),
        .inst_valid (inst_valid),
        .out_ready  (out_ready),
        .inst_pc    (inst_pc),
        .inst0      (inst0),
        .inst1      (inst1),
        .inst1_valid(inst1_valid),
        .fetch_excp (fetch_excp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. nb = beats the bus returns, gap = idle cycles before each beat.
    task automatic do_fetch(input logic [31:0] fpc, input logic unc, input int ar_wait,
                            input int nb, input int fmode, input int out_wait, input int gap,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] beat [4];
        logic [31:0] e0, e1;
        logic        ev1, eexc;
        int          n;
        bit          dropped;
        n       = unc ? 1 : 2;
        dropped = 0;
        beat[0] = d0;
        beat[1] = d1;
        beat[2] = d2;
        beat[3] = 32'h0;
        check("idle_stall", {31'd0, stall}, 32'd0);

        inst_rreq = 1'b1;
        pc        = fpc;
        iuncache  = unc;
        flush     = 1'b0;
        tick();
        inst_rreq = 1'b0;
        pc        = $urandom();
        iuncache  = 1'($urandom_range(0, 1));
        check("req_stall", {31'd0, stall}, 32'd1);

        if (fpc[1:0] != 2'b00) begin
            e0 = NOP; e1 = NOP; ev1 = 1'b0; eexc = 1'b1;
            check("mis_ar_valid", {31'd0, ar_valid}, 32'd0);
        end else begin
            e0   = beat[0];
            e1   = (nb >= 2) ? beat[1] : NOP;
            ev1  = (n == 2) && (nb >= 2);
            eexc = 1'b0;
            check("ar_valid", {31'd0, ar_valid}, 32'd1);
            check("ar_addr", ar_addr, fpc);
            check("ar_len", {24'd0, ar_len}, n - 1);
            check("ar_inst_valid", {31'd0, inst_valid}, 32'd0);
            for (int w = 0; w <= ar_wait; w++) begin
                ar_ready = (w == ar_wait);
                flush    = (fmode == FAr) && (w == 0);
                tick();
                ar_ready = 1'b0;
                flush    = 1'b0;
                if (w < ar_wait) begin
                    check("ar_hold_valid", {31'd0, ar_valid}, 32'd1);
                    check("ar_hold_addr", ar_addr, fpc);
                    check("ar_hold_len", {24'd0, ar_len}, n - 1);
                end
            end
            check("ar_done", {31'd0, ar_valid}, 32'd0);
            check("r_ready", {31'd0, r_ready}, 32'd1);
            if (fmode == FR) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                check("r_ready_flush", {31'd0, r_ready}, 32'd1);
            end
            for (int b = 0; b < nb; b++) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("r_gap_ready", {31'd0, r_ready}, 32'd1);
                end
                r_valid = 1'b1;
                r_data  = beat[b];
                r_last  = (b == nb - 1);
                flush   = (fmode == FLast) && (b == nb - 1);
                tick();
                r_valid = 1'b0;
                r_last  = 1'b0;
                flush   = 1'b0;
                r_data  = $urandom();
                if (b < nb - 1) begin
                    check("r_ready_mid", {31'd0, r_ready}, 32'd1);
                    check("r_iv_mid", {31'd0, inst_valid}, 32'd0);
                end
            end
            check("r_ready_end", {31'd0, r_ready}, 32'd0);
            dropped = (fmode == FAr) || (fmode == FR) || (fmode == FLast);
        end

        if (dropped) begin
            check("drop_iv", {31'd0, inst_valid}, 32'd0);
            check("drop_stall", {31'd0, stall}, 32'd0);
        end else begin
            for (int k = 0; k <= out_wait; k++) begin
                check("resp_iv", {31'd0, inst_valid}, 32'd1);
                check("resp_pc", inst_pc, fpc);
                check("resp_inst0", inst0, e0);
                check("resp_inst1", inst1, e1);
                check("resp_i1v", {31'd0, inst1_valid}, {31'd0, ev1});
                check("resp_excp", {31'd0, fetch_excp}, {31'd0, eexc});
                check("resp_stall", {31'd0, stall}, 32'd1);
                if (k < out_wait) begin
                    out_ready = 1'b0;
                    tick();
                end
            end
            if (fmode == FResp) begin
                flush     = 1'b1;
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            tick();
            flush     = 1'b0;
            out_ready = 1'b0;
            check("done_iv", {31'd0, inst_valid}, 32'd0);
            check("done_stall", {31'd0, stall}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rpc;
        int          unc, nb, sel, fm;

        rst = 1'b0;
        inst_rreq = 1'b0; iuncache = 1'b0; flush = 1'b0; ar_ready = 1'b0;
        r_valid = 1'b0; r_last = 1'b0; out_ready = 1'b0; pc = '0; r_data = '0;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_ar_valid", {31'd0, ar_valid}, 32'd0);
        check("rst_iv", {31'd0, inst_valid}, 32'd0);
        check("rst_inst0", inst0, 32'd0);
        check("rst_inst1", inst1, 32'd0);
        check("rst_ar_addr", ar_addr, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Directed scenarios
        do_fetch(32'h1c000000, 1'b1, 0, 1, FNone, 0, 0, 32'h02800404, 32'h0, 32'h0);
        do_fetch(32'h1c000008, 1'b0, 0, 2, FNone, 3, 0, 32'h11111111, 32'h22222222, 32'h0);
        do_fetch(32'h1c000002, 1'b0, 0, 2, FNone, 1, 0, 32'h0, 32'h0, 32'h0);
        do_fetch(32'h1c000010, 1'b0, 2, 2, FAr, 0, 0, 32'haaaa5555, 32'h5555aaaa, 32'h0);
        do_fetch(32'h1c000020, 1'b0, 0, 2, FLast, 0, 0, 32'h33333333, 32'h44444444, 32'h0);
        do_fetch(32'h1c000030, 1'b0, 0, 2, FResp, 2, 0, 32'h55555555, 32'h66666666, 32'h0);
        do_fetch(32'h1c000040, 1'b0, 1, 1, FNone, 0, 1, 32'h77777777, 32'h0, 32'h0);
        do_fetch(32'h1c000050, 1'b0, 0, 3, FNone, 0, 0, 32'h88888888, 32'h99999999, 32'h12345678);

        // Flush in IDLE drops the request
        inst_rreq = 1'b1; pc = 32'h1c000060; flush = 1'b1;
        tick();
        inst_rreq = 1'b0; flush = 1'b0;
        check("idle_flush_stall", {31'd0, stall}, 32'd0);
        check("idle_flush_ar", {31'd0, ar_valid}, 32'd0);

        // Asynchronous reset in the middle of the read phase
        inst_rreq = 1'b1; pc = 32'h1c000070; iuncache = 1'b0;
        tick();
        inst_rreq = 1'b0; ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        check("pre_rst_r_ready", {31'd0, r_ready}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_r_ready", {31'd0, r_ready}, 32'd0);
        check("arst_ar_addr", ar_addr, 32'd0);
        check("arst_ar_len", {24'd0, ar_len}, 32'd0);
        check("arst_inst_pc", inst_pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        do_fetch(32'h1c000080, 1'b0, 0, 2, FNone, 0, 0, 32'hcafef00d, 32'hdeadbeef, 32'h0);

        // Randomized transactions
        for (int t = 0; t < 300; t++) begin
            rpc = $urandom();
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            unc = $urandom_range(0, 1);
            nb  = unc ? 1 : 2;
            sel = $urandom_range(0, 7);
            if (unc == 0 && sel == 0) nb = 1;
            if (unc == 0 && sel == 1) nb = 3;
            sel = $urandom_range(0, 9);
            fm  = (sel <= 5) ? FNone : sel - 5;
            if ($urandom_range(0, 9) == 0) begin
                inst_rreq = 1'b1; pc = rpc; flush = 1'b1;
                tick();
                inst_rreq = 1'b0; flush = 1'b0;
                check("rnd_idle_flush", {31'd0, stall}, 32'd0);
            end
            do_fetch(rpc, 1'(unc), $urandom_range(0, 2), nb, fm, $urandom_range(0, 3),
                     $urandom_range(0, 1), $urandom(), $urandom(), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
